// File: rtl/atomic_counter_pkg.sv
// Shared types and default sizing for the split 64-bit counter reader.
// The reader fetches a wide counter as two bus-width halves and assembles them.
package atomic_counter_pkg;

  localparam int DATABUS_DEF  = 32;
  localparam int COUNTLEN_DEF = 64;
  localparam int TIMEOUT_DEF  = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

endpackage

// File: rtl/atomic_counter_reader_if.sv
// Handshake bundle between the counter reader, its requester and the counter.
// master is the reader itself; slave is the requester/counter side.
interface atomic_counter_reader_if
  import atomic_counter_pkg::*;
#(
  parameter int DATABUS  = DATABUS_DEF,
  parameter int COUNTLEN = COUNTLEN_DEF
);

  logic                start_i;
  logic                req_o;
  logic                atomic_o;
  logic                ack_i;
  logic [DATABUS-1:0]  count_i;
  logic [COUNTLEN-1:0] sample_o;
  logic [COUNTLEN-1:0] delta_o;
  logic                valid_o;
  logic                busy_o;
  logic                timeout_o;

  modport master (
    input  start_i, ack_i, count_i,
    output req_o, atomic_o, sample_o, delta_o, valid_o, busy_o, timeout_o
  );

  modport slave (
    output start_i, ack_i, count_i,
    input  req_o, atomic_o, sample_o, delta_o, valid_o, busy_o, timeout_o
  );

endinterface

// File: rtl/atomic_counter_reader_ack_timer.sv
// Wait-cycle counter for one half-read; expired flags the last allowed wait cycle.
// clear takes priority so every wait phase starts counting from zero.
module ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of wait cycles already completed
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/atomic_counter_reader.sv
// Reads a wide counter as an atomic low half (latching the MSBs) then the latched high half,
// publishing the assembled sample and its modular difference from the previous sample.
module atomic_counter_reader
  import atomic_counter_pkg::*;
#(
  parameter int DATABUS  = DATABUS_DEF,
  parameter int COUNTLEN = COUNTLEN_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input logic                    clk,
  input logic                    reset,
  atomic_counter_reader_if.master bus
);

  state_t              state;
  logic [DATABUS-1:0]  lo_half;
  logic [COUNTLEN-1:0] sample;
  logic [COUNTLEN-1:0] delta;
  logic [COUNTLEN-1:0] new_sample;
  logic                valid;
  logic                timeout;
  logic                timer_clear;
  logic                timer_en;
  logic                expired;

  function automatic logic [COUNTLEN-1:0] assemble(input logic [DATABUS-1:0] hi,
                                                   input logic [DATABUS-1:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic [COUNTLEN-1:0] wrap_delta(input logic [COUNTLEN-1:0] cur,
                                                     input logic [COUNTLEN-1:0] prev);
    return cur - prev;
  endfunction

  assign new_sample  = assemble(bus.count_i, lo_half);
  assign timer_clear = (state == REQ_LO) || (state == REQ_HI);
  assign timer_en    = (state == WAIT_LO) || (state == WAIT_HI);

  ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  // sample doubles as the previous sample for the next delta
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lo_half <= '0;
      sample  <= '0;
      delta   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE:    if (bus.start_i) state <= REQ_LO;
        REQ_LO:  state <= WAIT_LO;
        WAIT_LO: begin
          if (bus.ack_i) begin
            lo_half <= bus.count_i;
            state   <= REQ_HI;
          end else if (expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        REQ_HI:  state <= WAIT_HI;
        WAIT_HI: begin
          if (bus.ack_i) begin
            sample <= new_sample;
            delta  <= wrap_delta(new_sample, sample);
            valid  <= 1'b1;
            state  <= IDLE;
          end else if (expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // request strobes and busy decode straight from the state register
  assign bus.req_o     = (state == REQ_LO) || (state == REQ_HI);
  assign bus.atomic_o  = (state == REQ_LO);
  assign bus.busy_o    = (state != IDLE);
  assign bus.sample_o  = sample;
  assign bus.delta_o   = delta;
  assign bus.valid_o   = valid;
  assign bus.timeout_o = timeout;

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Directed bench for atomic_counter_reader with a behavioural split-read counter
// that answers one cycle after each request.
module tb_atomic_counter_reader;
  import atomic_counter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] ctr = '0;
  logic [31:0] hi_latch = '0;
  logic [31:0] resp_count = '0;
  logic [31:0] resp_next;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] stray_count = '0;
  logic        ack_lo_en = 1'b1;
  logic        ack_hi_en = 1'b1;

  atomic_counter_reader_if #(.DATABUS(32), .COUNTLEN(64)) bus ();

  atomic_counter_reader #(.DATABUS(32), .COUNTLEN(64), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.ack_i   = resp_ack | stray_ack;
  assign bus.count_i = stray_ack ? stray_count : resp_count;

  // Counter model: atomic read returns the low half and latches the high half.
  always @(negedge clk) begin
    if (bus.req_o === 1'b1 && !reset) begin
      if (bus.atomic_o === 1'b1) begin
        hi_latch  = ctr[63:32];
        resp_next = ctr[31:0];
      end else begin
        resp_next = hi_latch;
      end
      if ((bus.atomic_o && ack_lo_en) || (!bus.atomic_o && ack_hi_en)) begin
        @(posedge clk); #1;
        resp_ack   = 1'b1;
        resp_count = resp_next;
        @(posedge clk); #1;
        resp_ack   = 1'b0;
      end
    end
  end

  task automatic do_read(input logic [63:0] value, output int lat);
    ctr = value;
    lat = -1;
    bus.start_i = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (bus.valid_o === 1'b1 || bus.timeout_o === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.start_i = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.req_o, bus.atomic_o, bus.busy_o} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b want=000", {bus.req_o, bus.atomic_o, bus.busy_o}); end
    checks++; if ({bus.valid_o, bus.timeout_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b want=00", {bus.valid_o, bus.timeout_o}); end
    checks++; if (bus.sample_o !== 64'd0 || bus.delta_o !== 64'd0) begin errors++; $display("FAIL reset_data sample=%h delta=%h want 0", bus.sample_o, bus.delta_o); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_first_read;
    ctr = 64'h0000_0001_FFFF_FFFE;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    checks++; if ({bus.req_o, bus.atomic_o} !== 2'b11) begin errors++; $display("FAIL first_req_lo got=%b want=11", {bus.req_o, bus.atomic_o}); end
    @(posedge clk); #1;
    checks++; if ({bus.req_o, bus.atomic_o, bus.busy_o} !== 3'b001) begin errors++; $display("FAIL first_wait_lo got=%b want=001", {bus.req_o, bus.atomic_o, bus.busy_o}); end
    @(posedge clk); #1;
    checks++; if ({bus.req_o, bus.atomic_o} !== 2'b10) begin errors++; $display("FAIL first_req_hi got=%b want=10", {bus.req_o, bus.atomic_o}); end
    @(posedge clk); #1;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL first_valid_early got=%b want=0", bus.valid_o); end
    @(posedge clk); #1;
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL first_valid_k5 got=%b want=1", bus.valid_o); end
    checks++; if (bus.sample_o !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL first_sample got=%h want=00000001fffffffe", bus.sample_o); end
    checks++; if (bus.delta_o !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL first_delta got=%h want=00000001fffffffe", bus.delta_o); end
    @(posedge clk); #1;
    checks++; if ({bus.valid_o, bus.busy_o} !== 2'b00 || bus.sample_o !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL first_hold valid_busy=%b sample=%h", {bus.valid_o, bus.busy_o}, bus.sample_o); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_fast_increment;
    int lat;
    do_read(64'd100, lat);
    checks++; if (bus.sample_o !== 64'd100) begin errors++; $display("FAIL fast_sample1 got=%0d want=100", bus.sample_o); end
    repeat (2) @(posedge clk);
    #1;
    do_read(64'd1_000_100, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL fast_latency got=%0d want=5", lat); end
    checks++; if (bus.delta_o !== 64'd1_000_000) begin errors++; $display("FAIL fast_delta got=%0d want=1000000", bus.delta_o); end
  endtask

  task automatic test_wrap;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    do_read(64'hFFFF_FFFF_FFFF_FFF0, lat);
    repeat (2) @(posedge clk);
    #1;
    do_read(64'h0000_0000_0000_0010, lat);
    checks++; if (bus.sample_o !== 64'h10) begin errors++; $display("FAIL wrap_sample got=%h want=10", bus.sample_o); end
    checks++; if (bus.delta_o !== 64'h20) begin errors++; $display("FAIL wrap_delta got=%h want=20", bus.delta_o); end
  endtask

  task automatic test_back_to_back;
    int lat_a;
    int lat_b;
    repeat (2) @(posedge clk);
    #1;
    do_read(64'd500, lat_a);
    do_read(64'd800, lat_b);
    checks++; if (lat_b !== 5) begin errors++; $display("FAIL b2b_latency got=%0d want=5", lat_b); end
    checks++; if (bus.sample_o !== 64'd800 || bus.delta_o !== 64'd300) begin errors++; $display("FAIL b2b_data sample=%0d delta=%0d want 800/300", bus.sample_o, bus.delta_o); end
  endtask

  task automatic test_timeout;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    ack_hi_en = 1'b0;
    do_read(64'hABCD_0000_0000_0001, lat);
    checks++; if (lat !== 19) begin errors++; $display("FAIL timeout_latency got=%0d want=19", lat); end
    checks++; if ({bus.timeout_o, bus.valid_o, bus.busy_o} !== 3'b100) begin errors++; $display("FAIL timeout_flags got=%b want=100", {bus.timeout_o, bus.valid_o, bus.busy_o}); end
    checks++; if (bus.sample_o !== 64'd800 || bus.delta_o !== 64'd300) begin errors++; $display("FAIL timeout_keep sample=%0d delta=%0d want 800/300", bus.sample_o, bus.delta_o); end
    @(posedge clk); #1;
    checks++; if ({bus.timeout_o, bus.busy_o} !== 2'b00) begin errors++; $display("FAIL timeout_pulse got=%b want=00", {bus.timeout_o, bus.busy_o}); end
    ack_hi_en = 1'b1;
  endtask

  task automatic test_start_ignored;
    int lat;
    logic busy_seen;
    repeat (2) @(posedge clk);
    #1;
    ctr = 64'd5000;
    lat = -1;
    bus.start_i = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 3) bus.start_i = 1'b0;
      if (bus.valid_o === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL busy_start_latency got=%0d want=5", lat); end
    checks++; if (bus.delta_o !== 64'd4200) begin errors++; $display("FAIL busy_start_delta got=%0d want=4200", bus.delta_o); end
    busy_seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      busy_seen = busy_seen | bus.busy_o;
    end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL busy_start_requeued got=%b want=0", busy_seen); end
  endtask

  task automatic test_reset_in_wait_lo;
    int lat;
    logic pulse_seen;
    logic busy_seen;
    ack_lo_en = 1'b0;
    ctr = 64'd77;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rst_wait_busy got=%b want=1", bus.busy_o); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.req_o, bus.atomic_o, bus.busy_o, bus.valid_o, bus.timeout_o} !== 5'b0 || bus.sample_o !== 64'd0 || bus.delta_o !== 64'd0) begin
      errors++; $display("FAIL rst_async ctrl=%b sample=%h delta=%h want all 0", {bus.req_o, bus.atomic_o, bus.busy_o, bus.valid_o, bus.timeout_o}, bus.sample_o, bus.delta_o);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ack_lo_en = 1'b1;
    pulse_seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      pulse_seen = pulse_seen | bus.valid_o | bus.timeout_o;
    end
    checks++; if (pulse_seen !== 1'b0) begin errors++; $display("FAIL rst_late_pulse got=%b want=0", pulse_seen); end
    stray_count = 32'hDEAD_BEEF;
    stray_ack = 1'b1;
    busy_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      busy_seen = busy_seen | bus.busy_o | bus.valid_o;
    end
    stray_ack = 1'b0;
    checks++; if (busy_seen !== 1'b0 || bus.sample_o !== 64'd0) begin errors++; $display("FAIL stray_ack busy_valid=%b sample=%h want 0", busy_seen, bus.sample_o); end
    @(posedge clk); #1;
    do_read(64'h0000_0000_0000_1234, lat);
    checks++; if (lat !== 5 || bus.sample_o !== 64'h1234 || bus.delta_o !== 64'h1234) begin
      errors++; $display("FAIL post_reset_read lat=%0d sample=%h delta=%h want 5/1234/1234", lat, bus.sample_o, bus.delta_o);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    test_reset();
    test_first_read();
    test_fast_increment();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_start_ignored();
    test_reset_in_wait_lo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/atomic_counter_reader.md
ATOMIC_COUNTER_READER -- requirements
Module: atomic_counter_reader

Interface
REQ-001 SHALL have parameter DATABUS, default 32, counter read-bus width.
REQ-002 SHALL have parameter COUNTLEN, default 64, full counter width (= 2*DATABUS).
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waiting for ack_i per half-read.
REQ-004 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have start_i  input  1  single-cycle request to sample the counter.
REQ-007 SHALL have req_o  output  1  read request to the counter.
REQ-008 SHALL have atomic_o  output  1  1 = low-half read with MSB latch, 0 = latched-MSB read.
REQ-009 SHALL have ack_i  input  1  counter response strobe.
REQ-010 SHALL have count_i  input  DATABUS  counter response data, valid when ack_i=1.
REQ-011 SHALL have sample_o  output  COUNTLEN  last assembled 64-bit counter value.
REQ-012 SHALL have delta_o  output  COUNTLEN  sample_o minus previous sample, modulo 2^COUNTLEN.
REQ-013 SHALL have valid_o  output  1  one-cycle pulse: sample_o/delta_o updated.
REQ-014 SHALL have busy_o  output  1  high in every state except IDLE.
REQ-015 SHALL have timeout_o  output  1  one-cycle pulse: read aborted, no ack in time.

Function
REQ-016 SHALL implement Moore FSM states IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI.
REQ-017 SHALL in IDLE with start_i=1 go to REQ_LO; start_i outside IDLE SHALL be ignored (no queuing).
REQ-018 SHALL drive req_o=1, atomic_o=1 only in REQ_LO, for exactly one cycle, then go WAIT_LO.
REQ-019 SHALL in WAIT_LO with ack_i=1 capture count_i as low half and go REQ_HI.
REQ-020 SHALL drive req_o=1, atomic_o=0 only in REQ_HI, for exactly one cycle, then go WAIT_HI.
REQ-021 SHALL in WAIT_HI with ack_i=1 form sample = {count_i, low half}, go IDLE, pulse valid_o next cycle.
REQ-022 SHALL, with a counter that acks one cycle after req, pulse valid_o 5 cycles after the start_i edge (start at edge k -> valid_o high cycle k+5).
REQ-023 SHALL accept start_i in the cycle valid_o is high (back-to-back reads, 5-cycle period).
REQ-024 SHALL compute delta_o = new sample - previous sample, unsigned, wrapping modulo 2^COUNTLEN.
REQ-025 SHALL treat previous sample as 0 for the first read after reset (delta_o = sample_o).
REQ-026 SHALL count cycles in WAIT_LO/WAIT_HI; when count reaches TIMEOUT without ack_i: go IDLE, pulse timeout_o, leave sample_o/delta_o/previous sample unchanged.
REQ-027 SHALL restart the wait counter at zero on each entry to WAIT_LO and WAIT_HI.
REQ-028 SHALL ignore ack_i in IDLE, REQ_LO and REQ_HI (stray acks dropped, no state change).
REQ-029 SHALL hold sample_o and delta_o stable between valid_o pulses.
REQ-030 SHALL keep req_o=0 and atomic_o=0 in IDLE, WAIT_LO, WAIT_HI.

Reset
REQ-031 SHALL on reset force state IDLE, req_o=0, atomic_o=0, valid_o=0, timeout_o=0, busy_o=0, sample_o=0, delta_o=0, previous sample=0, wait counter=0.
REQ-032 SHALL abort any in-flight read on reset with no valid_o or timeout_o pulse afterwards.

Structure
REQ-033 SHALL place the FSM state enum and DATABUS/COUNTLEN/TIMEOUT defaults in shared package atomic_counter_pkg.
REQ-034 SHALL implement the wait counter as sub-module ack_timer (inputs clear, enable; output expired).
REQ-035 SHALL register all outputs except req_o, atomic_o, busy_o, which decode directly from the state register.

Verification
REQ-036 SHALL cover: counter at 0x0000_0001_FFFF_FFFE, trig off, start_i pulse -> req/atomic=1 then req/atomic=0, valid_o at k+5, sample_o=0x0000_0001_FFFF_FFFE, delta_o same.
REQ-037 SHALL cover: two reads, counter 100 then 1_000_100 (fast increments) -> second delta_o=1_000_000.
REQ-038 SHALL cover: previous sample 0xFFFF_FFFF_FFFF_FFF0, new sample 0x10 -> delta_o=0x20 (wrap).
REQ-039 SHALL cover: ack_i withheld in WAIT_HI -> timeout_o pulse after 15 wait cycles, state IDLE, sample_o unchanged.
REQ-040 SHALL cover: reset asserted in WAIT_LO -> all outputs 0 immediately, no later valid_o; start_i during busy and stray ack_i in IDLE have no effect.
